vsr_line_fetch: RTL

- Per-plane video line fetcher downstream of the ICA/DCA controller; consumes its reload_vsr/vsr pulse and fetches pixel words from RAM in 4-word bursts into a small FIFO drained by the pixel decoder.
- Uses the same bus protocol as the ICA/DCA controller; both sit behind the plane's memory arbiter.

---
 rtl/vsr_line_fetch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vsr_line_fetch.sv
// Per-plane video line fetcher: reads each active line from RAM in 4-word bursts into a fall-through FIFO.
// Optional LINE_FETCH_UNDERFLOW_EN adds sticky underflow flag and saturating underflow counter outputs.
module vsr_line_fetch #(
  parameter int WORDS_PER_LINE = 384,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reload_vsr,
  input  logic [21:0] vsr,
  input  logic        line_start,
  output logic [21:0] address,
  output logic        as,
  input  logic [15:0] din,
  input  logic        burstdata_valid,
  input  logic        bus_ack,
  input  logic        pix_rd,
  output logic [15:0] pix_data,
  output logic        pix_empty,
  output logic        line_done
`ifdef LINE_FETCH_UNDERFLOW_EN
  ,
  output logic        underflow,
  output logic [15:0] underflow_cnt
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WLW = $clog2(WORDS_PER_LINE + 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

  state_t state, next_state;

  logic [21:0]    cur_ptr;
  logic [21:0]    vsr_ptr;
  logic [21:0]    pending_ptr;
  logic           pending_valid;
  logic [WLW-1:0] words_left;

  logic [15:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic space_ok;
  logic burst_busy;
  logic fifo_push;
  logic fifo_pop;

  // A burst is only requested when all four of its words are guaranteed a slot.
  assign space_ok   = (count <= CW'(FIFO_DEPTH - 4));
  assign burst_busy = (state == DATA) || (state == DRAIN);
  assign fifo_push  = (state == DATA) && burstdata_valid && (words_left != '0) && !line_start;
  assign fifo_pop   = pix_rd && (count != '0) && !line_start;

  assign pix_data  = fifo_mem[rd_ptr];
  assign pix_empty = (count == '0);
  assign line_done = !reset && fifo_push && (words_left == WLW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (line_start) begin
      // An outstanding burst must still be terminated by bus_ack before a new request.
      if (burst_busy && !bus_ack) next_state = DRAIN;
      else                        next_state = REQ;
    end else begin
      case (state)
        IDLE:  next_state = IDLE;
        REQ: begin
          if (words_left == '0) next_state = IDLE;
          else if (space_ok)    next_state = DATA;
        end
        DATA:  if (bus_ack) next_state = REQ;
        DRAIN: if (bus_ack) next_state = REQ;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      as            <= 1'b0;
      address       <= '0;
      cur_ptr       <= '0;
      vsr_ptr       <= '0;
      pending_ptr   <= '0;
      pending_valid <= 1'b0;
      words_left    <= '0;
    end else begin
      if (reload_vsr) begin
        pending_ptr   <= vsr;
        pending_valid <= 1'b1;
      end
      if (line_start) begin
        // A reload in the same cycle wins; otherwise continue where the last burst ended.
        if (reload_vsr)         cur_ptr <= vsr;
        else if (pending_valid) cur_ptr <= pending_ptr;
        else                    cur_ptr <= vsr_ptr;
        pending_valid <= 1'b0;
        words_left    <= WLW'(WORDS_PER_LINE);
        as            <= burst_busy && !bus_ack;
      end else begin
        case (state)
          REQ: begin
            if ((words_left != '0) && space_ok) begin
              as      <= 1'b1;
              address <= cur_ptr;
            end
          end
          DATA: begin
            if (burstdata_valid && (words_left != '0)) words_left <= words_left - WLW'(1);
            if (bus_ack) begin
              as      <= 1'b0;
              cur_ptr <= cur_ptr + 22'd8;
              vsr_ptr <= cur_ptr + 22'd8;
            end
          end
          DRAIN: if (bus_ack) as <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // A new line flushes the FIFO, overriding any push or pop in that cycle.
  always_ff @(posedge clk) begin
    if (reset || line_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= din;
  end

`ifdef LINE_FETCH_UNDERFLOW_EN
  // Reads on an empty FIFO only count while a line is being fetched.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (pix_rd && pix_empty && ((words_left != '0) || (state != IDLE))) begin
      underflow <= 1'b1;
      if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`else
  // Without the monitor a read on an empty FIFO is simply ignored.
`endif

endmodule
